// File: rtl/pwm_breath_ctrl.sv
// pwm_breath_ctrl -- sequencer producing a "breathing" duty profile by
// driving the pwm_en / inc / dec controls of a pwm instance.
//
// The profile ramps the duty up to duty_max, holds, ramps it down to
// duty_min, holds, and repeats until stop. A shadow copy of the pwm duty
// tells the sequencer when a limit has been reached.
//
// Optional feature: define BREATH_ONESHOT_EN to run one profile period only.
// At the end of the first HOLD_LOW the sequencer returns to IDLE and pulses
// done. Without the macro the profile repeats and done is tied low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        level, accepted only in IDLE (configuration is checked)
//   stop         level, aborts the profile from any non-IDLE state
//   duty_ini     initial duty (the same value is fed to the pwm duty_ini)
//   duty_min     lower ramp limit
//   duty_max     upper ramp limit
//   step_div     cycles between duty steps, minus one
//   hold_len     hold duration, minus one
//   pwm_en       enable to the pwm
//   inc, dec     one-cycle duty step pulses to the pwm
//   duty_shadow  controller copy of the pwm duty
//   busy         high in every state except IDLE
//   cfg_err      one-cycle pulse when a start is rejected
//   done         one-cycle pulse when a one-shot profile completes
module pwm_breath_ctrl #(
  parameter int DUTY_W = 7,
  parameter int DIV_W  = 16,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DUTY_W-1:0] duty_ini,
  input  logic [DUTY_W-1:0] duty_min,
  input  logic [DUTY_W-1:0] duty_max,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              pwm_en,
  output logic              inc,
  output logic              dec,
  output logic [DUTY_W-1:0] duty_shadow,
  output logic              busy,
  output logic              cfg_err,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_HOLD_HIGH,
    S_RAMP_DOWN,
    S_HOLD_LOW
  } state_t;

  state_t            state_reg, state_next;
  logic [DUTY_W-1:0] min_reg, min_next;
  logic [DUTY_W-1:0] max_reg, max_next;
  logic [DUTY_W-1:0] shadow_reg, shadow_next;
  logic [DIV_W-1:0]  div_cfg_reg, div_cfg_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [HOLD_W-1:0] hold_cfg_reg, hold_cfg_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              pwm_en_reg, pwm_en_next;
  logic              inc_reg, inc_next;
  logic              dec_reg, dec_next;
  logic              busy_reg, busy_next;
  logic              cfg_err_reg, cfg_err_next;
`ifdef BREATH_ONESHOT_EN
  logic              done_reg, done_next;
`endif

  logic              cfg_bad;
  logic [DUTY_W-1:0] shadow_up;
  logic [DUTY_W-1:0] shadow_dn;

  assign cfg_bad   = (duty_min > duty_max) || (duty_ini < duty_min) ||
                     (duty_ini > duty_max);
  assign shadow_up = shadow_reg + 1'b1;
  assign shadow_dn = shadow_reg - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      min_reg      <= '0;
      max_reg      <= '0;
      shadow_reg   <= '0;
      div_cfg_reg  <= '0;
      div_cnt_reg  <= '0;
      hold_cfg_reg <= '0;
      hold_cnt_reg <= '0;
      pwm_en_reg   <= 1'b0;
      inc_reg      <= 1'b0;
      dec_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      cfg_err_reg  <= 1'b0;
`ifdef BREATH_ONESHOT_EN
      done_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      min_reg      <= min_next;
      max_reg      <= max_next;
      shadow_reg   <= shadow_next;
      div_cfg_reg  <= div_cfg_next;
      div_cnt_reg  <= div_cnt_next;
      hold_cfg_reg <= hold_cfg_next;
      hold_cnt_reg <= hold_cnt_next;
      pwm_en_reg   <= pwm_en_next;
      inc_reg      <= inc_next;
      dec_reg      <= dec_next;
      busy_reg     <= busy_next;
      cfg_err_reg  <= cfg_err_next;
`ifdef BREATH_ONESHOT_EN
      done_reg     <= done_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    min_next      = min_reg;
    max_next      = max_reg;
    shadow_next   = shadow_reg;
    div_cfg_next  = div_cfg_reg;
    div_cnt_next  = div_cnt_reg;
    hold_cfg_next = hold_cfg_reg;
    hold_cnt_next = hold_cnt_reg;
    pwm_en_next   = pwm_en_reg;
    busy_next     = busy_reg;
    inc_next      = 1'b0;
    dec_next      = 1'b0;
    cfg_err_next  = 1'b0;
`ifdef BREATH_ONESHOT_EN
    done_next     = 1'b0;
`endif

    if (state_reg != S_IDLE && stop) begin
      // Abort: any step due at this edge is dropped, the shadow keeps the
      // duty the pwm actually holds.
      state_next    = S_IDLE;
      pwm_en_next   = 1'b0;
      busy_next     = 1'b0;
      div_cnt_next  = '0;
      hold_cnt_next = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && !stop) begin
            if (cfg_bad) begin
              cfg_err_next = 1'b1;
            end else begin
              min_next      = duty_min;
              max_next      = duty_max;
              div_cfg_next  = step_div;
              hold_cfg_next = hold_len;
              shadow_next   = duty_ini;
              pwm_en_next   = 1'b1;
              busy_next     = 1'b1;
              div_cnt_next  = '0;
              hold_cnt_next = '0;
              state_next    = (duty_ini < duty_max) ? S_RAMP_UP : S_HOLD_HIGH;
            end
          end
        end

        S_RAMP_UP: begin
          if (div_cnt_reg == div_cfg_reg) begin
            inc_next     = 1'b1;
            shadow_next  = shadow_up;
            div_cnt_next = '0;
            if (shadow_up == max_reg) begin
              state_next    = S_HOLD_HIGH;
              hold_cnt_next = '0;
            end
          end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
          end
        end

        S_RAMP_DOWN: begin
          if (div_cnt_reg == div_cfg_reg) begin
            dec_next     = 1'b1;
            shadow_next  = shadow_dn;
            div_cnt_next = '0;
            if (shadow_dn == min_reg) begin
              state_next    = S_HOLD_LOW;
              hold_cnt_next = '0;
            end
          end else begin
            div_cnt_next = div_cnt_reg + 1'b1;
          end
        end

        S_HOLD_HIGH: begin
          if (hold_cnt_reg == hold_cfg_reg) begin
            hold_cnt_next = '0;
            div_cnt_next  = '0;
            // With min==max there is nothing to ramp; go straight across.
            state_next    = (shadow_reg == min_reg) ? S_HOLD_LOW : S_RAMP_DOWN;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end

        S_HOLD_LOW: begin
          if (hold_cnt_reg == hold_cfg_reg) begin
            hold_cnt_next = '0;
            div_cnt_next  = '0;
`ifdef BREATH_ONESHOT_EN
            state_next    = S_IDLE;
            pwm_en_next   = 1'b0;
            busy_next     = 1'b0;
            done_next     = 1'b1;
`else
            state_next    = (shadow_reg == max_reg) ? S_HOLD_HIGH : S_RAMP_UP;
`endif
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_next  = S_IDLE;
          pwm_en_next = 1'b0;
          busy_next   = 1'b0;
        end
      endcase
    end
  end

  assign pwm_en      = pwm_en_reg;
  assign inc         = inc_reg;
  assign dec         = dec_reg;
  assign duty_shadow = shadow_reg;
  assign busy        = busy_reg;
  assign cfg_err     = cfg_err_reg;
`ifdef BREATH_ONESHOT_EN
  assign done        = done_reg;
`else
  assign done        = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Self-checking bench for pwm_breath_ctrl: a table of start attempts
// (accepted and rejected configurations) plus hand-written sequences for
// the long breathing profile, stop/abort, flat profile, a short profile and
// asynchronous reset. Expected pulse positions come from hand-derived
// timelines (k = cycles after the accepting start edge).
module tb_pwm_breath_ctrl;

`ifdef BREATH_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [6:0]  duty_ini = '0;
  logic [6:0]  duty_min = '0;
  logic [6:0]  duty_max = '0;
  logic [15:0] step_div = '0;
  logic [15:0] hold_len = '0;
  logic        pwm_en, inc, dec, busy, cfg_err, done;
  logic [6:0]  duty_shadow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_breath_ctrl #(.DUTY_W(7), .DIV_W(16), .HOLD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .duty_ini(duty_ini), .duty_min(duty_min), .duty_max(duty_max),
    .step_div(step_div), .hold_len(hold_len),
    .pwm_en(pwm_en), .inc(inc), .dec(dec), .duty_shadow(duty_shadow),
    .busy(busy), .cfg_err(cfg_err), .done(done)
  );

  typedef struct {
    int ini, mn, mx;
    bit exp_err;
    bit exp_busy;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ini, input int mn, input int mx, input int dv, input int hl);
    duty_ini = 7'(ini);
    duty_min = 7'(mn);
    duty_max = 7'(mx);
    step_div = 16'(dv);
    hold_len = 16'(hl);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic to_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  function automatic bit on_grid(input int k, input int s, input int e, input int p);
    return (k > s) && (k <= e) && (((k - s) % p) == 0);
  endfunction

  initial begin
    int bad_inc, bad_dec, bad_busy, bad_done, both, range_bad;
    int n_inc, n_dec, kmax;
    bit exp_i, exp_d, exp_b, exp_dn;

    vecs[0] = '{60, 25, 120, 1'b0, 1'b1};
    vecs[1] = '{75, 100, 50, 1'b1, 1'b0};
    vecs[2] = '{10, 25, 120, 1'b1, 1'b0};
    vecs[3] = '{121, 25, 120, 1'b1, 1'b0};
    vecs[4] = '{25, 25, 120, 1'b0, 1'b1};
    vecs[5] = '{120, 25, 120, 1'b0, 1'b1};
    vecs[6] = '{40, 40, 40, 1'b0, 1'b1};

    // Reset state
    step(); step();
    check("rst_pwm_en", pwm_en, 0);
    check("rst_busy", busy, 0);
    check("rst_inc_dec", {inc, dec}, 0);
    check("rst_shadow", duty_shadow, 0);
    check("rst_cfg_err_done", {cfg_err, done}, 0);
    rst_n = 1'b1;
    step();

    // Table of start attempts
    for (int v = 0; v < 7; v++) begin
      cfg(vecs[v].ini, vecs[v].mn, vecs[v].mx, 3, 9);
      do_start();
      $display("vec %0d ini=%0d min=%0d max=%0d cfg_err=%0d busy=%0d pwm_en=%0d shadow=%0d",
               v, vecs[v].ini, vecs[v].mn, vecs[v].mx, cfg_err, busy, pwm_en, duty_shadow);
      check($sformatf("vec%0d_cfg_err", v), cfg_err, vecs[v].exp_err);
      check($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
      check($sformatf("vec%0d_pwm_en", v), pwm_en, vecs[v].exp_busy);
      check($sformatf("vec%0d_inc_dec", v), {inc, dec}, 0);
      if (!vecs[v].exp_err) check($sformatf("vec%0d_shadow", v), duty_shadow, vecs[v].ini);
      step();
      check($sformatf("vec%0d_cfg_err_once", v), cfg_err, 0);
      check($sformatf("vec%0d_busy_k1", v), busy, vecs[v].exp_busy);
      to_idle();
    end

    // Long profile: ini=60 min=25 max=120 step_div=3 hold_len=9
    cfg(60, 25, 120, 3, 9);
    do_start();
    check("long_pwm_en_k0", pwm_en, 1);
    bad_inc = 0; bad_dec = 0; bad_busy = 0; bad_done = 0;
    both = 0; range_bad = 0; n_inc = 0; n_dec = 0;
    kmax = ONESHOT ? 645 : 2195;
    for (int k = 0; k <= kmax; k++) begin
      exp_i = on_grid(k, 0, 240, 4) ||
              (!ONESHOT && (on_grid(k, 640, 1020, 4) || on_grid(k, 1420, 1800, 4)));
      exp_d = on_grid(k, 250, 630, 4) ||
              (!ONESHOT && (on_grid(k, 1030, 1410, 4) || on_grid(k, 1810, 2190, 4)));
      exp_b = !ONESHOT || (k < 640);
      exp_dn = ONESHOT && (k == 640);
      if (inc !== exp_i) bad_inc++;
      if (dec !== exp_d) bad_dec++;
      if (busy !== exp_b) bad_busy++;
      if (done !== exp_dn) bad_done++;
      if (inc && dec) both++;
      if (busy && (duty_shadow < 25 || duty_shadow > 120)) range_bad++;
      if (k > 630 && inc) n_inc++;
      if (k > 630 && dec) n_dec++;
      if (k == 240) check("long_shadow_max", duty_shadow, 120);
      if (k == 630) check("long_shadow_min", duty_shadow, 25);
      step();
    end
    $display("long profile: inc_mismatch=%0d dec_mismatch=%0d incs=%0d decs=%0d",
             bad_inc, bad_dec, n_inc, n_dec);
    check("long_inc_timing", bad_inc, 0);
    check("long_dec_timing", bad_dec, 0);
    check("long_busy", bad_busy, 0);
    check("long_done", bad_done, 0);
    check("long_inc_and_dec", both, 0);
    check("long_shadow_range", range_bad, 0);
    check("long_inc_eq_dec", n_inc, n_dec);
    check("long_inc_count", n_inc, ONESHOT ? 0 : 190);
    to_idle();

    // Stop in RAMP_UP on the divider-terminal cycle; start and config
    // changes while busy must be ignored.
    cfg(60, 25, 120, 3, 9);
    do_start();
    for (int k = 0; k <= 13; k++) begin
      if (k == 1) duty_max = 7'd61;
      if (k == 5) begin start = 1'b1; duty_ini = 7'd100; end
      if (k == 6) begin
        start = 1'b0;
        check("stop_restart_ignored", duty_shadow, 61);
        check("stop_busy_k6", busy, 1);
      end
      if (k == 11) stop = 1'b1;
      if (k == 12) begin
        stop = 1'b0;
        $display("stop: inc=%0d pwm_en=%0d busy=%0d shadow=%0d", inc, pwm_en, busy, duty_shadow);
        check("stop_no_inc", inc, 0);
        check("stop_pwm_en", pwm_en, 0);
        check("stop_busy", busy, 0);
        check("stop_shadow", duty_shadow, 62);
      end
      if (k == 13) check("stop_shadow_hold", {inc, duty_shadow}, 62);
      step();
    end
    to_idle();

    // Flat profile: min=max=ini=40, hold_len=0
    cfg(40, 40, 40, 0, 0);
    do_start();
    bad_busy = 0; bad_done = 0; both = 0;
    for (int k = 0; k <= 9; k++) begin
      if (inc || dec) both++;
      if (busy !== (!ONESHOT || k < 2)) bad_busy++;
      if (done !== (ONESHOT && k == 2)) bad_done++;
      step();
    end
    $display("flat profile: pulses=%0d shadow=%0d", both, duty_shadow);
    check("flat_no_pulses", both, 0);
    check("flat_busy", bad_busy, 0);
    check("flat_done", bad_done, 0);
    check("flat_shadow", duty_shadow, 40);
    to_idle();

    // Short profile: ini=25 min=25 max=30 step_div=0 hold_len=1
    cfg(25, 25, 30, 0, 1);
    do_start();
    bad_inc = 0; bad_dec = 0; bad_busy = 0; bad_done = 0;
    for (int k = 0; k <= 16; k++) begin
      exp_i = (k >= 1 && k <= 5) || (!ONESHOT && k >= 15);
      exp_d = (k >= 8 && k <= 12);
      if (inc !== exp_i) bad_inc++;
      if (dec !== exp_d) bad_dec++;
      if (busy !== (!ONESHOT || k < 14)) bad_busy++;
      if (pwm_en !== (!ONESHOT || k < 14)) bad_busy++;
      if (done !== (ONESHOT && k == 14)) bad_done++;
      if (k == 5) check("short_shadow_max", duty_shadow, 30);
      if (k == 12) check("short_shadow_min", duty_shadow, 25);
      if (k == 16) check("short_shadow_end", duty_shadow, ONESHOT ? 25 : 27);
      step();
    end
    check("short_inc", bad_inc, 0);
    check("short_dec", bad_dec, 0);
    check("short_busy_pwm_en", bad_busy, 0);
    check("short_done", bad_done, 0);
    to_idle();

    // Asynchronous reset in the middle of a ramp
    cfg(60, 25, 120, 0, 9);
    do_start();
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: pwm_en=%0d busy=%0d shadow=%0d", pwm_en, busy, duty_shadow);
    check("arst_pwm_en", pwm_en, 0);
    check("arst_busy", busy, 0);
    check("arst_shadow", duty_shadow, 0);
    check("arst_inc_dec", {inc, dec}, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    check("arst_stays_idle", {busy, pwm_en, inc}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
